// File: rtl/or_arbiter.sv
// Round-robin arbiter that computes a | b for one granted requester per cycle.
// A single-entry registered response slot supports one result per cycle under back-to-back accepts.
module or_arbiter #(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         req_ready,
    output logic                 rsp_valid,
    output logic [W-1:0]         rsp_y,
    output logic [$clog2(N)-1:0] rsp_id,
    input  logic                 rsp_ready,
    output logic [15:0]          txn_count
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_y_q, rsp_y_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]   txn_q, txn_d;

    logic          found;
    logic [IW-1:0] gnt;
    logic [IW:0]   idx;
    logic          slot_free;
    logic          accept;

    // Cyclic search starting at ptr; idx carries one extra bit so the wrap works for any N.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[IW-1:0];
            end
        end
    end

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign accept    = slot_free && found && !rst;
    assign req_ready = accept ? (N'(1) << gnt) : '0;

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        txn_d       = txn_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = req_a[gnt*W +: W] | req_b[gnt*W +: W];
            rsp_id_d    = gnt;
            ptr_d       = (gnt == IW'(N-1)) ? '0 : gnt + IW'(1);
            if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            txn_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            txn_q       <= txn_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign txn_count = txn_q;
endmodule

// File: tb/tb_or_arbiter.sv
// Directed bench for or_arbiter (N=4, W=1): vector table plus rotation and saturation sequences.
module tb_or_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_a, req_b, req_ready;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_y;
    logic [1:0]  rsp_id;
    logic [15:0] txn_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    or_arbiter #(.N(4), .W(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .txn_count(txn_count)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld, a, b;
        logic        rr;
        logic [3:0]  rdy;   // combinational, before the edge
        logic        v, y;  // registered, after the edge
        logic [1:0]  id;
        logic [15:0] txn;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic r, logic [3:0] vld, logic [3:0] a, logic [3:0] b, logic rr,
                                logic [3:0] rdy, logic v, logic y, logic [1:0] id, logic [15:0] txn);
        vec_t t;
        t.rst = r; t.vld = vld; t.a = a; t.b = b; t.rr = rr;
        t.rdy = rdy; t.v = v; t.y = y; t.id = id; t.txn = txn;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        step();

        //              rst vld      a        b        rr   rdy      v  y  id  txn
        tbl[0]  = mk(1, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0, 1);
        tbl[2]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
        tbl[3]  = mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 2, 2);
        tbl[4]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 1, 2, 3);
        tbl[5]  = mk(0, 4'b0100, 4'b0000, 4'b0000, 1, 4'b0100, 1, 0, 2, 4);
        tbl[6]  = mk(0, 4'b0100, 4'b0000, 4'b0100, 1, 4'b0100, 1, 1, 2, 5);
        tbl[7]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 5);
        tbl[8]  = mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0010, 1, 0, 1, 6);
        tbl[9]  = mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 6);
        tbl[10] = mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 6);
        tbl[11] = mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 6);
        tbl[12] = mk(1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        tbl[13] = mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 4'b1000, 1, 1, 3, 1);
        tbl[14] = mk(0, 4'b1001, 4'b1111, 4'b0000, 1, 4'b0001, 1, 1, 0, 2);
        tbl[15] = mk(0, 4'b1001, 4'b0000, 4'b1111, 1, 4'b1000, 1, 1, 3, 3);

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; req_valid = tbl[i].vld; req_a = tbl[i].a; req_b = tbl[i].b;
            rsp_ready = tbl[i].rr;
            #3;
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            step();
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("vec%0d rsp_y", i), 32'(rsp_y), 32'(tbl[i].y));
                chk($sformatf("vec%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
            end
            chk($sformatf("vec%0d txn_count", i), 32'(txn_count), 32'(tbl[i].txn));
        end

        // Round-robin rotation with all requesters held valid.
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        step();
        rst = 1'b0; req_valid = 4'b1111; req_a = 4'b0000; req_b = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr%0d rsp_id", k), 32'(rsp_id), 32'(k % 4));
        end
        chk("rr txn_count", 32'(txn_count), 32'd8);

        // Saturation of the accept counter.
        rst = 1'b1; req_valid = '0;
        step();
        rst = 1'b0; req_valid = 4'b1111;
        for (int k = 1; k <= 65537; k++) begin
            step();
            if (k == 65534) chk("sat 65534", 32'(txn_count), 32'hFFFE);
            if (k == 65535) chk("sat 65535", 32'(txn_count), 32'hFFFF);
            if (k == 65536) chk("sat 65536", 32'(txn_count), 32'hFFFF);
            if (k == 65537) chk("sat 65537", 32'(txn_count), 32'hFFFF);
        end
        chk("sat rsp_valid", 32'(rsp_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/or_arbiter.md
OR_ARBITER -- requirements
Module: or_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter W, default 1: operand and result width in bits.
REQ-003 clk  input  1: sole clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 req_valid  input  N: bit i set means requester i presents an operand pair.
REQ-006 req_a  input  N*W: operand a; requester i occupies bits [i*W +: W].
REQ-007 req_b  input  N*W: operand b, packed the same way as req_a.
REQ-008 req_ready  output  N: one-hot or zero; bit i set means requester i's pair is accepted this cycle.
REQ-009 rsp_valid  output  1: the response registers hold a result.
REQ-010 rsp_y  output  W: registered result, a | b, bitwise.
REQ-011 rsp_id  output  clog2(N): index of the requester that owns rsp_y.
REQ-012 rsp_ready  input  1: consumer takes the response this cycle.
REQ-013 txn_count  output  16: saturating count of accepted requests.

Function
REQ-014 Slot free = !rsp_valid || rsp_ready; acceptance is possible only when the slot is free.
REQ-015 Grant g = first i with req_valid[i], searching cyclically from ptr; ptr is a clog2(N)-bit register.
REQ-016 req_ready[g] shall be asserted combinationally when the slot is free and any req_valid bit is set; all other req_ready bits shall be 0.
REQ-017 req_ready shall be all-zero when the slot is not free or req_valid == 0.
REQ-018 On accept: next cycle rsp_valid=1, rsp_y = req_a[g] | req_b[g], rsp_id = g; latency is exactly 1 cycle.
REQ-019 On accept, ptr <= (g+1) mod N; ptr holds otherwise, so every persistently-valid requester is granted within N accepts.
REQ-020 Response held (rsp_valid && !rsp_ready): rsp_valid, rsp_y and rsp_id shall be stable.
REQ-021 rsp_ready with no new accept: rsp_valid <= 0 next cycle.
REQ-022 rsp_ready with a simultaneous accept: the response registers load the new result; rsp_valid stays 1, giving a sustained throughput of 1 result per cycle.
REQ-023 rsp_ready while rsp_valid=0 shall be ignored.
REQ-024 txn_count shall increment by 1 per accept and saturate at 0xFFFF (no wrap).
REQ-025 A requester that drops req_valid before it is granted is skipped, and no state changes for it.
REQ-026 ptr wraps from N-1 to 0.

Reset
REQ-027 When rst=1 at a clock edge: rsp_valid=0, rsp_y=0, rsp_id=0, ptr=0, txn_count=0.
REQ-028 While rst=1, req_ready shall be all-zero.
REQ-029 A response pending when rst is asserted is discarded and never presented to the consumer.

Verification
REQ-030 After reset, with N=4 and W=1: req_valid=0001, a=1, b=0, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_y=1, rsp_id=0.
REQ-031 With req_valid=1111 held and rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, and txn_count=8.
REQ-032 Backpressure: rsp_ready=0 for 3 cycles with req_valid=0010 and a=b=0 -> rsp_valid=1, rsp_y=0, rsp_id=1 stable; req_ready=0000; txn_count=1.
REQ-033 Truth table via requester 2: (a,b) = (1,1), (1,0), (0,0), (0,1) -> rsp_y = 1, 1, 0, 1, each with rsp_id=2.
REQ-034 Reset mid-operation: rsp_valid=1 and rsp_ready=0, then rst=1 for one cycle -> rsp_valid=0; the next grant with req_valid=1000 is requester 3, because ptr=0.
REQ-035 Saturation: 65536 accepts -> txn_count=0xFFFF; one further accept leaves it at 0xFFFF.
